// File: rtl/pattern_detector_param_pkg.sv
// pattern_detector_param_pkg
//   Shared definitions for the serial pattern-detector family.
//   - fillWidth(): width of the fill counter that tracks how much history is primed
//   - ovl_mode_e / OVL_ON / OVL_OFF: overlap mode encoding
//   - PAT_1011 / PAT_1111 / PAT_0110: pattern constants reused by other detectors
package pattern_detector_param_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } ovl_mode_e;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  localparam logic [3:0] PAT_1011 = 4'b1011;
  localparam logic [3:0] PAT_1111 = 4'b1111;
  localparam logic [3:0] PAT_0110 = 4'b0110;

  // Fill states run 0..N-1, so clog2(N) bits always suffice.
  function automatic int fillWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_detector_param_if.sv
// pattern_detector_param_if
//   Serial input / control / result bundle for pattern_detector_param.
//   master: drives en, in, load, pat, overlap, clr_cnt; receives q, count, busy_fill
//   slave : the detector itself
interface pattern_detector_param_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  logic          en;
  logic          in;
  logic          load;
  logic [N-1:0]  pat;
  logic          overlap;
  logic          clr_cnt;
  logic          q;
  logic [CW-1:0] count;
  logic          busy_fill;

  modport master (
    output en, in, load, pat, overlap, clr_cnt,
    input  q, count, busy_fill
  );

  modport slave (
    input  en, in, load, pat, overlap, clr_cnt,
    output q, count, busy_fill
  );
endinterface

// File: rtl/pattern_detector_param_window.sv
// pattern_window
//   Holds the last N-1 accepted bits (newest in bit 0) and compares the
//   N-bit window {history, in} against the active pattern.
//   Ports: clk, rst (sync, active-high), clear (empty the history),
//          shift (accept in), in (serial bit), pat (N-bit pattern),
//          eq (window equals pattern, combinational)
module pattern_window #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic         in,
  input  logic [N-1:0] pat,
  output logic         eq
);

  logic [N-2:0] hist_q;
  logic [N-2:0] hist_d;

  // With N = 2 the history is a single bit, so there is nothing to shift along.
  if (N == 2) begin : g_hist_one
    assign hist_d = in;
  end else begin : g_hist_many
    assign hist_d = {hist_q[N-3:0], in};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
    end else if (shift) begin
      hist_q <= hist_d;
    end
  end

  assign eq = ({hist_q, in} == pat);

endmodule

// File: rtl/pattern_detector_param.sv
// pattern_detector_param
//   Parametrised Moore serial-pattern detector with reloadable pattern and
//   overlap mode, registered one-cycle match pulse and saturating match count.
//   Ports: clk (rising edge), rst (sync, active-high),
//          bus.slave: en, in, load, pat, overlap, clr_cnt -> q, count, busy_fill
module pattern_detector_param
  import pattern_detector_param_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] DEFAULT_PAT = N'(PAT_1011),
  parameter logic         DEFAULT_OVL = OVL_ON,
  parameter int           CW          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  pattern_detector_param_if.slave  bus
);

  localparam int             FW       = fillWidth(N);
  localparam logic [FW-1:0]  FILL_RUN = FW'(N - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  logic [N-1:0]  patReg_q;
  ovl_mode_e     ovlReg_q;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;
  logic          match_q;
  logic [CW-1:0] count_q;
  logic          eq;
  logic          hit;

  // History is emptied on load and never sees the bit dropped in that cycle.
  pattern_window #(.N(N)) u_window (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.load),
    .shift (bus.en && !bus.load),
    .in    (bus.in),
    .pat   (patReg_q),
    .eq    (eq)
  );

  assign hit = bus.en && !bus.load && (fill_q == FILL_RUN) && eq;

  // A non-overlapping match throws the window away, so the next match
  // needs N fresh bits; otherwise fill climbs to RUN and stays there.
  always_comb begin
    fill_d = fill_q;
    if (hit && (ovlReg_q == MODE_NONOVL)) begin
      fill_d = '0;
    end else if (fill_q != FILL_RUN) begin
      fill_d = fill_q + 1'b1;
    end
  end

  // Fill FSM (FILL_0..FILL_N-2, RUN), loaded configuration and match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      patReg_q <= DEFAULT_PAT;
      ovlReg_q <= ovl_mode_e'(DEFAULT_OVL);
      fill_q   <= '0;
      match_q  <= 1'b0;
    end else if (bus.load) begin
      patReg_q <= bus.pat;
      ovlReg_q <= ovl_mode_e'(bus.overlap);
      fill_q   <= '0;
      match_q  <= 1'b0;
    end else if (bus.en) begin
      fill_q   <= fill_d;
      match_q  <= hit;
    end else begin
      match_q  <= 1'b0;
    end
  end

  // Clear beats a coincident hit; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      count_q <= '0;
    end else if (hit && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.q         = match_q;
  assign bus.count     = count_q;
  assign bus.busy_fill = (fill_q < FILL_RUN);

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb_pattern_detector_param
//   Directed bench for pattern_detector_param. DUT A: N=4, 1011, overlap, CW=8.
//   DUT B: N=2, 11, overlap, CW=2 (counter saturation).
//   Expected q/count/busy_fill are queued when a step is driven and popped
//   once the DUT has taken the edge.
module tb_pattern_detector_param;
  import pattern_detector_param_pkg::*;

  typedef struct {
    int         sel;
    string      tag;
    logic       q;
    logic [7:0] count;
    logic       busy;
  } exp_t;

  logic clk;
  logic rstA;
  logic rstB;
  int   assertCount = 0;
  int   failCount   = 0;
  exp_t expQueue[$];

  pattern_detector_param_if #(.N(4), .CW(8)) busA ();
  pattern_detector_param_if #(.N(2), .CW(2)) busB ();

  pattern_detector_param #(
    .N(4), .DEFAULT_PAT(4'b1011), .DEFAULT_OVL(1'b1), .CW(8)
  ) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA)
  );

  pattern_detector_param #(
    .N(2), .DEFAULT_PAT(2'b11), .DEFAULT_OVL(1'b1), .CW(2)
  ) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge and queue what the DUT must show after the next rising edge.
  task automatic applyStimulus(input int sel, input logic rst, input logic en, input logic in,
                               input logic load, input logic [3:0] pat, input logic ovl,
                               input logic clr, input logic expQ, input logic [7:0] expCount,
                               input logic expBusy, input string tag);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      rstA = rst; busA.en = en; busA.in = in; busA.load = load;
      busA.pat = pat; busA.overlap = ovl; busA.clr_cnt = clr;
    end else begin
      rstB = rst; busB.en = en; busB.in = in; busB.load = load;
      busB.pat = pat[1:0]; busB.overlap = ovl; busB.clr_cnt = clr;
    end
    e.sel = sel; e.tag = tag; e.q = expQ; e.count = expCount; e.busy = expBusy;
    expQueue.push_back(e);
  endtask

  // Let the edge happen, then compare the oldest queued expectation.
  task automatic checkOutput();
    exp_t       e;
    logic       obsQ;
    logic [7:0] obsCount;
    logic       obsBusy;
    @(posedge clk);
    #1;
    assertCount++;
    assert (expQueue.size() != 0) else begin
      failCount++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (expQueue.size() != 0) begin
      e = expQueue.pop_front();
      if (e.sel == 0) begin
        obsQ = busA.q; obsCount = busA.count; obsBusy = busA.busy_fill;
      end else begin
        obsQ = busB.q; obsCount = {6'd0, busB.count}; obsBusy = busB.busy_fill;
      end
      assertCount++;
      assert (obsQ === e.q) else begin
        failCount++;
        $error("FAIL %s_q observed=%0b expected=%0b", e.tag, obsQ, e.q);
      end
      assertCount++;
      assert (obsCount === e.count) else begin
        failCount++;
        $error("FAIL %s_count observed=%0d expected=%0d", e.tag, obsCount, e.count);
      end
      assertCount++;
      assert (obsBusy === e.busy) else begin
        failCount++;
        $error("FAIL %s_busy observed=%0b expected=%0b", e.tag, obsBusy, e.busy);
      end
    end
  endtask

  task automatic step(input int sel, input logic rst, input logic en, input logic in,
                      input logic load, input logic [3:0] pat, input logic ovl, input logic clr,
                      input logic expQ, input logic [7:0] expCount, input logic expBusy,
                      input string tag);
    applyStimulus(sel, rst, en, in, load, pat, ovl, clr, expQ, expCount, expBusy, tag);
    checkOutput();
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1;
    busA.en = 0; busA.in = 0; busA.load = 0; busA.pat = '0; busA.overlap = 0; busA.clr_cnt = 0;
    busB.en = 0; busB.in = 0; busB.load = 0; busB.pat = '0; busB.overlap = 0; busB.clr_cnt = 0;

    // DUT A reset state
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "A_reset");

    // Defaults 1011 overlapping: stream 1,0,1,1,0,1,1
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t1_b1");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t1_b2");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t1_b3");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd1, 0, "t1_b4");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 8'd1, 0, "t1_b5");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd1, 0, "t1_b6");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd2, 0, "t1_b7");
    step(0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 8'd2, 0, "t1_idle");

    // 1111 non-overlapping, 8 ones
    step(0, 0, 0, 0, 1, 4'hF, 0, 1, 0, 8'd0, 1, "t2_load");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t2_b1");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t2_b2");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t2_b3");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd1, 1, "t2_b4");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd1, 1, "t2_b5");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd1, 1, "t2_b6");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd1, 0, "t2_b7");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd2, 1, "t2_b8");

    // 1111 overlapping, 8 ones
    step(0, 0, 0, 0, 1, 4'hF, 1, 1, 0, 8'd0, 1, "t3_load");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t3_b1");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t3_b2");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t3_b3");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd1, 0, "t3_b4");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd2, 0, "t3_b5");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd3, 0, "t3_b6");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd4, 0, "t3_b7");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd5, 0, "t3_b8");

    // 1011 with an en=0 gap while in toggles
    step(0, 0, 0, 0, 1, PAT_1011, 1, 1, 0, 8'd0, 1, "t4_load");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t4_b1");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t4_b2");
    step(0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t4_gap1");
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t4_gap2");
    step(0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t4_gap3");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t4_b3");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd1, 0, "t4_b4");

    // Load 0110 mid-stream with en=1, in=1 on the load cycle
    step(0, 0, 0, 0, 1, PAT_1011, 1, 1, 0, 8'd0, 1, "t5_load1");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t5_b1");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t5_b2");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t5_b3");
    step(0, 0, 1, 1, 1, PAT_0110, 1, 0, 0, 8'd0, 1, "t5_load2");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t5_c1");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t5_c2");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t5_c3");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 1, 8'd1, 0, "t5_c4");

    // Reset in the cycle that would complete 1011
    step(0, 0, 0, 0, 1, PAT_1011, 1, 0, 0, 8'd1, 1, "t6_load");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd1, 1, "t6_b1");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 8'd1, 1, "t6_b2");
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd1, 0, "t6_b3");
    step(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t6_rst");

    // DUT B: N=2, pattern 11, CW=2
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0, 1, "B_reset");
    step(1, 0, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 0, "t7_b1");
    step(1, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd1, 0, "t7_b2");
    step(1, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd2, 0, "t7_b3");
    step(1, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd3, 0, "t7_b4");
    step(1, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd3, 0, "t7_b5");
    step(1, 0, 1, 1, 0, 4'h0, 0, 0, 1, 8'd3, 0, "t7_b6");
    step(1, 0, 1, 1, 0, 4'h0, 0, 1, 1, 8'd0, 0, "t7_clr_hit");
    step(1, 1, 1, 1, 0, 4'h0, 0, 0, 0, 8'd0, 1, "t7_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
